// File: rtl/except_struct_pkg.sv
// Exception record carried alongside an instruction through the pipeline.
package ExceptStruct;

    typedef struct packed {
        logic        except;
        logic [63:0] pc;
        logic [4:0]  ecause;
        logic [63:0] tval;
    } ExceptPack;

endpackage

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM-stage access controller.
package MemStruct;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [4:0] CAUSE_LOAD_MISALIGN  = 5'd4;
    localparam logic [4:0] CAUSE_STORE_MISALIGN = 5'd6;

    // funct3[1:0] encodes the access size for both signed and unsigned forms.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] offs);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return offs[0];
            2'b10:   return |offs[1:0];
            default: return |offs;
        endcase
    endfunction

    function automatic logic [7:0] store_mask(input logic [2:0] funct3, input logic [2:0] offs);
        case (funct3[1:0])
            2'b00:   return 8'h01 << offs;
            2'b01:   return 8'h03 << offs;
            2'b10:   return 8'h0F << offs;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Selects the addressed lane of a 64-bit read beat and sign/zero-extends it.
module load_extend
    import MemStruct::*;
(
    input  logic [63:0] i_data,
    input  logic [2:0]  i_offs,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_data
);

    logic [63:0] w_lane;

    assign w_lane = i_data >> {i_offs, 3'b000};

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{56{w_lane[7]}},  w_lane[7:0]};
            F3_H:    o_data = {{48{w_lane[15]}}, w_lane[15:0]};
            F3_W:    o_data = {{32{w_lane[31]}}, w_lane[31:0]};
            F3_D:    o_data = w_lane;
            F3_BU:   o_data = {56'd0, w_lane[7:0]};
            F3_HU:   o_data = {48'd0, w_lane[15:0]};
            F3_WU:   o_data = {32'd0, w_lane[31:0]};
            default: o_data = w_lane;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage controller: issues one data-memory request per load/store,
// waits for load data, and holds the pipeline until the result is ready.
module mem_access
    import ExceptStruct::*;
    import MemStruct::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid,
    input  logic [63:0] MEM_pc,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [2:0]  mem_funct3,
    input  logic [63:0] mem_addr_in,
    input  logic [63:0] mem_wdata_in,
    input  ExceptPack   except_in,
    input  logic        MEM_flush,
    input  logic        MEM_WB_stall,
    output logic        MEM_stall,
    output logic [63:0] MEM_rw_rdata,
    output ExceptPack   except_mem,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wmask,
    input  logic        dmem_resp_valid,
    input  logic [63:0] dmem_resp_data
);

    mem_state_e  r_state;
    mem_state_e  w_next;
    logic [63:0] r_rdata;

    logic [2:0]  w_offs;
    logic        w_access;
    logic        w_misaligned;
    logic        w_mis_exc;
    logic        w_op;
    logic        w_req;
    logic        w_store_req;
    logic [63:0] w_ext_data;

    assign w_offs       = mem_addr_in[2:0];
    assign w_access     = MEM_valid & (mem_re | mem_we);
    assign w_misaligned = is_misaligned(mem_funct3, w_offs);
    assign w_mis_exc    = w_access & ~except_in.except & w_misaligned;
    assign w_op         = w_access & ~except_in.except & ~w_misaligned & ~MEM_flush;

    // Requests leave only from IDLE, so at most one access is ever outstanding.
    assign w_req        = ~rst & (r_state == S_IDLE) & w_op;
    assign w_store_req  = w_req & mem_we;

    load_extend u_load_extend (
        .i_data   (dmem_resp_data),
        .i_offs   (w_offs),
        .i_funct3 (mem_funct3),
        .o_data   (w_ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_WAIT) && dmem_resp_valid && !MEM_flush) begin
                r_rdata <= w_ext_data;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        MEM_stall    = 1'b0;
        MEM_rw_rdata = '0;
        case (r_state)
            S_IDLE: begin
                MEM_stall = w_op & (mem_re | ~dmem_req_ready);
                if (w_op && dmem_req_ready && mem_re) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                MEM_stall = 1'b1;
                // A flush beats a same-cycle response; the beat is consumed here.
                if (MEM_flush) begin
                    w_next = dmem_resp_valid ? S_IDLE : S_DRAIN;
                end else if (dmem_resp_valid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                MEM_rw_rdata = r_rdata;
                if (!MEM_WB_stall || MEM_flush) begin
                    w_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                MEM_stall = 1'b1;
                if (dmem_resp_valid) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            MEM_stall = 1'b0;
        end
    end

    assign dmem_req_valid = w_req;
    assign dmem_req_we    = w_store_req;
    assign dmem_addr      = w_req ? {mem_addr_in[63:3], 3'b000} : 64'd0;
    assign dmem_wdata     = w_store_req ? (mem_wdata_in << {w_offs, 3'b000}) : 64'd0;
    assign dmem_wmask     = w_store_req ? store_mask(mem_funct3, w_offs) : 8'd0;

    always_comb begin
        except_mem = except_in;
        if (w_mis_exc) begin
            except_mem.except = 1'b1;
            except_mem.pc     = MEM_pc;
            except_mem.ecause = mem_re ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
            except_mem.tval   = mem_addr_in;
        end
        if (rst) begin
            except_mem = '0;
        end
    end

endmodule
